// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: the master drives count controls,
// the slave (the counter) returns the registered count and flags.
interface updown_mod_counter_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic             up;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] max_val;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;
    logic             done;

    modport master (
        output en, up, step, max_val, ld, ld_val, clr_ovf,
        input  q, tc, ovf, done
    );

    modport slave (
        input  en, up, step, max_val, ld, ld_val, clr_ovf,
        output q, tc, ovf, done
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Programmable up/down modulo counter with load, wrap/saturate policy, terminal-count
// pulse, sticky overflow flag and an optional one-shot DONE state.
module updown_mod_counter #(
    parameter int WIDTH   = 6,
    parameter int SAT     = 0,
    parameter int ONESHOT = 0,
    parameter int RST_VAL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_mod_counter_if.slave  bus
);
    localparam int W1 = WIDTH + 1;
    localparam logic [W1-1:0]    ONE_X   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_Q  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] RST_Q   = RST_VAL[WIDTH-1:0];
    localparam logic             SAT_EN  = (SAT != 32'sd0);
    localparam logic             ONE_EN  = (ONESHOT != 32'sd0);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             ovf_r;
    logic             done_r;

    logic [WIDTH-1:0] next_q_s;
    logic [WIDTH-1:0] ld_q_s;
    logic             cross_s;
    logic             active_s;
    logic [W1-1:0]    q_x_s;
    logic [W1-1:0]    step_x_s;
    logic [W1-1:0]    max_x_s;
    logic [W1-1:0]    sum_x_s;
    logic [W1-1:0]    wrap_up_s;
    logic [W1-1:0]    wrap_dn_s;

    // Widened arithmetic so carry and borrow are visible in the top bit.
    always_comb begin
        q_x_s     = {1'b0, q_r};
        step_x_s  = {1'b0, bus.step};
        max_x_s   = {1'b0, bus.max_val};
        sum_x_s   = q_x_s + step_x_s;
        wrap_up_s = sum_x_s - max_x_s - ONE_X;
        wrap_dn_s = q_x_s + max_x_s + ONE_X - step_x_s;
        active_s  = bus.en && (bus.step != ZERO_Q) && (state_r == RUN);
        if (bus.ld_val > bus.max_val) begin
            ld_q_s = bus.max_val;
        end else begin
            ld_q_s = bus.ld_val;
        end
    end

    // Next count and crossing detection for one enabled step.
    always_comb begin
        next_q_s = q_r;
        cross_s  = 1'b0;
        if (!active_s) begin
            next_q_s = q_r;
            cross_s  = 1'b0;
        end else if (bus.up) begin
            if (q_x_s > max_x_s) begin
                // Limit was lowered beneath the current count.
                cross_s  = 1'b1;
                next_q_s = SAT_EN ? bus.max_val : ZERO_Q;
            end else if (sum_x_s <= max_x_s) begin
                next_q_s = sum_x_s[WIDTH-1:0];
            end else begin
                cross_s = 1'b1;
                if (SAT_EN) begin
                    next_q_s = bus.max_val;
                end else if (wrap_up_s > max_x_s) begin
                    next_q_s = ZERO_Q;
                end else begin
                    next_q_s = wrap_up_s[WIDTH-1:0];
                end
            end
        end else begin
            if (q_x_s > max_x_s) begin
                cross_s  = 1'b1;
                next_q_s = bus.max_val;
            end else if (q_x_s >= step_x_s) begin
                next_q_s = q_r - bus.step;
            end else begin
                // A negative wrap result lands far above max_val and clamps.
                cross_s = 1'b1;
                if (SAT_EN) begin
                    next_q_s = ZERO_Q;
                end else if (wrap_dn_s > max_x_s) begin
                    next_q_s = bus.max_val;
                end else begin
                    next_q_s = wrap_dn_s[WIDTH-1:0];
                end
            end
        end
    end

    // Count register, flags and RUN/DONE state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= RST_Q;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            state_r <= RUN;
        end else if (bus.ld) begin
            q_r     <= ld_q_s;
            tc_r    <= 1'b0;
            ovf_r   <= ovf_r;
            done_r  <= 1'b0;
            state_r <= RUN;
        end else begin
            q_r  <= next_q_s;
            tc_r <= cross_s;
            if (cross_s) begin
                ovf_r <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            case (state_r)
                RUN: begin
                    if (cross_s && ONE_EN) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= RUN;
                        done_r  <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= RUN;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.tc   = tc_r;
    assign bus.ovf  = ovf_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three instances (wrap, saturate, one-shot) driven from a
// vector table; expected results go through a scoreboard queue and are checked after each edge.
module tb_updown_mod_counter;
    localparam int W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   rst_v, en_v, up_v, ld_v, clr_v;
    logic [W-1:0] step_v [3];
    logic [W-1:0] max_v  [3];
    logic [W-1:0] ldv_v  [3];
    logic [W-1:0] q_v    [3];
    logic [2:0]   tc_v, ovf_v, done_v;

    updown_mod_counter_if #(.WIDTH(W)) bus [3] ();

    // Instance 0: wrap, instance 1: saturate, instance 2: wrap + one-shot.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].en      = en_v[g];
        assign bus[g].up      = up_v[g];
        assign bus[g].step    = step_v[g];
        assign bus[g].max_val = max_v[g];
        assign bus[g].ld      = ld_v[g];
        assign bus[g].ld_val  = ldv_v[g];
        assign bus[g].clr_ovf = clr_v[g];
        assign q_v[g]         = bus[g].q;
        assign tc_v[g]        = bus[g].tc;
        assign ovf_v[g]       = bus[g].ovf;
        assign done_v[g]      = bus[g].done;
        updown_mod_counter #(
            .WIDTH(W), .SAT((g == 1) ? 1 : 0), .ONESHOT((g == 2) ? 1 : 0), .RST_VAL(0)
        ) u_dut (
            .clk(clk),
            .rst(rst_v[g]),
            .bus(bus[g])
        );
    end

    typedef struct {
        int sel;
        bit rst, ld, en, up, clr;
        int step, maxv, ldv;
        int eq;
        bit etc, eovf, edone;
    } vec_t;

    typedef struct {
        int sel;
        int eq;
        bit etc, eovf, edone;
        int idx;
    } exp_t;

    vec_t vecs [$];
    exp_t sb   [$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;

    function automatic vec_t mk(int sel, bit rst, bit ld, bit en, bit up, int step, int maxv,
                                int ldv, bit clr, int eq, bit etc, bit eovf, bit edone);
        vec_t v;
        v.sel = sel; v.rst = rst; v.ld = ld; v.en = en; v.up = up; v.clr = clr;
        v.step = step; v.maxv = maxv; v.ldv = ldv;
        v.eq = eq; v.etc = etc; v.eovf = eovf; v.edone = edone;
        return v;
    endfunction

    function automatic void add(int sel, bit rst, bit ld, bit en, bit up, int step, int maxv,
                                int ldv, bit clr, int eq, bit etc, bit eovf, bit edone);
        vecs.push_back(mk(sel, rst, ld, en, up, step, maxv, ldv, clr, eq, etc, eovf, edone));
    endfunction

    task automatic chk(string nm, int idx, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        exp_t e;
        rst_v = 3'b000; en_v = 3'b000; ld_v = 3'b000; clr_v = 3'b000;
        rst_v[v.sel]  = v.rst;
        en_v[v.sel]   = v.en;
        up_v[v.sel]   = v.up;
        ld_v[v.sel]   = v.ld;
        clr_v[v.sel]  = v.clr;
        step_v[v.sel] = W'(v.step);
        max_v[v.sel]  = W'(v.maxv);
        ldv_v[v.sel]  = W'(v.ldv);
        sb.push_back('{v.sel, v.eq, v.etc, v.eovf, v.edone, vec_no});
        vec_no++;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk("q",    e.idx, int'(q_v[e.sel]),    e.eq);
            chk("tc",   e.idx, int'(tc_v[e.sel]),   int'(e.etc));
            chk("ovf",  e.idx, int'(ovf_v[e.sel]),  int'(e.eovf));
            chk("done", e.idx, int'(done_v[e.sel]), int'(e.edone));
        end
    endtask

    initial begin
        rst_v = 3'b111; en_v = 3'b000; up_v = 3'b111; ld_v = 3'b000; clr_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step_v[i] = '0; max_v[i] = 6'd63; ldv_v[i] = '0;
        end
        #2;

        // sel rst ld en up step max ldv clr | q tc ovf done
        for (int i = 0; i < 3; i++) add(i, 1, 0, 0, 1, 0, 63, 0, 0,  0, 0, 0, 0);

        // Full-range wrap from reset.
        for (int i = 0; i < 70; i++)
            add(0, 0, 0, 1, 1, 1, 63, 0, 0, (i + 1) % 64, i == 63, i >= 63, 0);

        // Down count with wrap: distance around the ring is max_val+1.
        add(0, 1, 0, 0, 0, 0, 9, 0, 0,  0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 9, 3, 0,  3, 0, 0, 0);
        add(0, 0, 0, 1, 0, 5, 9, 0, 0,  8, 1, 1, 0);
        add(0, 0, 0, 1, 0, 5, 9, 0, 0,  3, 0, 1, 0);
        add(0, 0, 0, 1, 0, 5, 9, 0, 0,  8, 1, 1, 0);

        // Saturating counter: hold at the limit keeps flagging crossings.
        add(1, 0, 0, 1, 1, 4, 10, 0, 0,  4, 0, 0, 0);
        add(1, 0, 0, 1, 1, 4, 10, 0, 0,  8, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 1, 4, 10, 0, 0, 10, 1, 1, 0);
        add(1, 0, 0, 1, 0, 4, 10, 0, 0,  6, 0, 1, 0);
        add(1, 0, 0, 1, 0, 4, 10, 0, 0,  2, 0, 1, 0);
        add(1, 0, 0, 1, 0, 4, 10, 0, 0,  0, 1, 1, 0);
        add(1, 0, 0, 1, 0, 4, 10, 0, 0,  0, 1, 1, 0);

        // One-shot: stop after the first wrap until reloaded.
        for (int k = 1; k <= 5; k++) add(2, 0, 0, 1, 1, 1, 5, 0, 0, k, 0, 0, 0);
        add(2, 0, 0, 1, 1, 1, 5, 0, 0,  0, 1, 1, 1);
        add(2, 0, 0, 1, 1, 1, 5, 0, 0,  0, 0, 1, 1);
        add(2, 0, 0, 1, 1, 1, 5, 0, 0,  0, 0, 1, 1);
        add(2, 0, 1, 1, 1, 1, 5, 2, 0,  2, 0, 1, 0);
        add(2, 0, 0, 1, 1, 1, 5, 0, 0,  3, 0, 1, 0);

        // Priority, load clamp and overflow clear.
        add(0, 0, 1, 0, 1, 0, 63, 20, 0, 20, 0, 1, 0);
        add(0, 1, 1, 1, 1, 1, 63, 50, 0,  0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 1, 40, 50, 0, 40, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 40, 0, 1,   0, 1, 1, 0);
        add(0, 0, 0, 0, 1, 1, 40, 0, 1,   0, 0, 0, 0);

        // max_val lowered under the count, max_val=0, step 0, step above max_val.
        add(0, 0, 1, 0, 1, 0, 63, 30, 0, 30, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 10, 0, 0,   0, 1, 1, 0);
        add(0, 0, 1, 0, 1, 0, 63, 30, 0, 30, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 10, 0, 0,  10, 1, 1, 0);
        add(0, 0, 0, 1, 1, 3, 0, 0, 0,    0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 3, 0, 0, 0,    0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 2, 0, 0, 0,    0, 1, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0,    0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1,    0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 9, 5, 0,    5, 0, 0, 0);
        add(0, 0, 0, 1, 1, 15, 9, 0, 0,   0, 1, 1, 0);
        add(0, 0, 1, 0, 1, 0, 9, 5, 0,    5, 0, 1, 0);
        add(0, 0, 0, 1, 1, 12, 9, 0, 0,   7, 1, 1, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Hand sequence: reset mid-count, then direction flip on consecutive edges.
        apply(mk(0, 0, 1, 0, 1, 0, 63, 10, 0, 10, 0, 1, 0));
        apply(mk(0, 0, 0, 1, 1, 2, 63, 0, 0,  12, 0, 1, 0));
        apply(mk(0, 1, 0, 1, 1, 2, 63, 0, 0,   0, 0, 0, 0));
        apply(mk(0, 0, 0, 1, 1, 2, 63, 0, 0,   2, 0, 0, 0));
        apply(mk(0, 0, 0, 1, 0, 1, 63, 0, 0,   1, 0, 0, 0));
        apply(mk(0, 0, 0, 1, 1, 3, 63, 0, 0,   4, 0, 0, 0));
        apply(mk(0, 0, 0, 1, 0, 5, 63, 0, 0,  63, 1, 1, 0));
        apply(mk(0, 0, 0, 1, 1, 1, 63, 0, 0,   0, 1, 1, 0));

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
